imem_loader: RTL and testbench
==============================

# imem_loader

Serial boot loader that writes the instruction memory the CPU fetches from. It consumes a byte stream from the UART receiver, frames it into 32-bit instruction words and issues word writes to the instruction memory. While a load is in progress it holds the CPU in reset, so a new program can be installed without resynthesising the instruction store.

## Interface

- `ADDR_WIDTH`, default 6: word-address bits of instruction memory; depth = 2^ADDR_WIDTH words (64).
- `TIMEOUT_CYCLES`, default 1000000: maximum idle gap between bytes inside a frame.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe per received byte; may arrive on back-to-back cycles.
- `mem_we`  out  1  instruction-memory write enable; one-cycle pulse per word.
- `mem_addr`  out  32  byte address, word aligned; bits [1:0] = 0, bits above ADDR_WIDTH+1 = 0.
- `mem_wdata`  out  32  instruction word; stable while `mem_we` = 1.
- `cpu_hold`  out  1  holds CPU in reset while high.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on a successful frame.
- `error`  out  1  one-cycle pulse on frame abort.

## Operation

- Frame: SYNC_BYTE, COUNT (number of words N), then N words sent MSB byte first, then CHECKSUM (if enabled).
- CHECKSUM = 8-bit sum mod 256 of COUNT and all 4N data bytes.
- States:
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE go to LEN, set `cpu_hold` = 1, clear the word index and checksum.
  - LEN: if COUNT = 0 or COUNT > 2^ADDR_WIDTH, pulse `error` and go to IDLE. Otherwise latch N, add COUNT to the sum, go to DATA.
  - DATA: shift each byte into the word register, byte index 0..3. On byte 3, register `mem_wdata` and `mem_addr` = index<<2, and pulse `mem_we`. After word N-1 go to CSUM, or finish directly when checksum is disabled.
  - CSUM: on a match, pulse `done`, set `cpu_hold` = 0, go to IDLE. On a mismatch, pulse `error` and go to IDLE.
- After an error, `cpu_hold` stays 1 (the partial image is not executed) until a later frame completes with `done`.
- Words already written are not rolled back on error.
- Timeout: an idle counter is cleared on every `rx_valid` and counts in LEN/DATA/CSUM. When it reaches TIMEOUT_CYCLES, pulse `error` and go to IDLE.
- A SYNC_BYTE value received inside a frame is treated as data; frames never nest.

## Timing

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0. State = IDLE, counters = 0.
- Reset asserted mid-frame aborts immediately; no `error` pulse. After reset, the CPU runs whatever is already in memory.
- `mem_we` is asserted in the cycle after the `rx_valid` of byte 3 of each word, and `mem_addr`/`mem_wdata` are valid in that same cycle.
- `done`/`error` are asserted the cycle after the deciding `rx_valid`. `cpu_hold` falls in the same cycle as `done`.
- `cpu_hold` rises the cycle after SYNC_BYTE is accepted.
- Back-to-back `rx_valid` is fully supported. A new byte arriving during the `mem_we` cycle is assembled without loss.
- A timeout `error` fires exactly TIMEOUT_CYCLES cycles after the last accepted in-frame byte.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined: the CSUM state exists and a trailing checksum byte is required and compared.
- Not defined: no checksum byte is expected. `done` pulses and `cpu_hold` falls in the same cycle as the final `mem_we`, and the state returns to IDLE.

## Test plan

- Checksum enabled; send A5 02 08 00 00 03 08 00 00 30 45 -> `mem_we` at addr 0x0 with data 08000003, then at addr 0x4 with data 08000030. `done` pulses once, `cpu_hold` 1→0, `error` never asserts.
- Same frame with checksum 46 -> both writes occur, `error` pulses, `cpu_hold` stays 1. A following correct frame then gives `done` and `cpu_hold` = 0.
- Send A5 41 (65 > 64 words) -> `error` the next cycle, no `mem_we`, state IDLE. Repeat with A5 00 -> same response.
- Send 00 FF 3C before any frame -> no outputs change, `busy` = 0, `cpu_hold` = 0.
- TIMEOUT_CYCLES = 16; send A5 01 20 08, then silence -> `error` exactly 16 cycles after byte 08, no `mem_we`. A subsequent full frame succeeds.
- Drive `reset` low after A5 03 plus 5 data bytes -> all outputs at reset values with no `error` pulse. After release, a full frame loads normally from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Serial boot loader: frames a UART byte stream into 32-bit words and writes instruction memory.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int         ADDR_WIDTH     = 6,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
  // timer_q holds (idle cycles - 1), so firing here puts error exactly TIMEOUT_CYCLES after the byte
  localparam logic [TW-1:0] TO_FIRE = TW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    last_idx_d  = last_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (state_q == S_IDLE || rx_valid) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d    = S_LEN;
            cpu_hold_d = 1'b1;
            word_idx_d = '0;
            byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (rx_data == 8'd0 || {24'd0, rx_data} > DEPTH) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            last_idx_d = ADDR_WIDTH'(rx_data - 8'd1);
            state_d    = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = rx_data;
`endif
          end
        end
        S_DATA: begin
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q, rx_data};
            mem_addr_d  = 32'(word_idx_q) << 2;
            if (word_idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d    = S_CSUM;
`else
              state_d    = S_IDLE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
`endif
            end else begin
              word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          state_d = S_IDLE;
          if (rx_data == sum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && timer_q == TO_FIRE) begin
      error_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      last_idx_q  <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      last_idx_q  <= last_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected per-byte responses are derived from frame contents.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(6), .TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        dn;
    logic        er;
    logic        bs;
    logic        hd;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] wq[$];
  logic        hold_m;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [7:0] b, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic dn, input logic er,
                         input logic bs, input logic hd);
    ev_t e;
    e.b = b; e.we = we; e.addr = addr; e.data = data;
    e.dn = dn; e.er = er; e.bs = bs; e.hd = hd;
    evq.push_back(e);
  endtask

  task automatic fill_words(input int n);
    logic [31:0] w;
    wq.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(3, 0) == 0) w[15:8] = 8'hA5;
      wq.push_back(w);
    end
  endtask

  // Frame from wq: writes land at 4*i on the 4th byte of word i; completion on the last byte
  task automatic push_frame(input int n, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    bit         last;
    s = n[7:0];
    push_ev(8'hA5, 0, 0, 0, 0, 0, 1, 1);
    push_ev(n[7:0], 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = wq[i][31-8*j -: 8];
        s = s + b;
        last = (i == n - 1) && (j == 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_ev(b, j == 3, i * 4, wq[i], 0, 0, 1, 1);
`else
        push_ev(b, j == 3, i * 4, wq[i], last, 0, !last, !last);
`endif
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (corrupt) begin
      push_ev(s + 8'd1, 0, 0, 0, 0, 1, 0, 1);
      hold_m = 1'b1;
    end else begin
      push_ev(s, 0, 0, 0, 1, 0, 0, 0);
      hold_m = 1'b0;
    end
`else
    hold_m = 1'b0;
`endif
  endtask

  task automatic push_badlen(input logic [7:0] c);
    push_ev(8'hA5, 0, 0, 0, 0, 0, 1, 1);
    push_ev(c, 0, 0, 0, 0, 1, 0, 1);
    hold_m = 1'b1;
  endtask

  task automatic push_garbage(input logic [7:0] b);
    push_ev((b == 8'hA5) ? 8'h00 : b, 0, 0, 0, 0, 0, 0, hold_m);
  endtask

  // Entered and left on a negedge; gap of 0 gives back-to-back rx_valid
  task automatic run_queue(input string label, input int maxgap);
    ev_t e;
    int  g;
    int  nb;
    nb = evq.size();
    while (evq.size() > 0) begin
      e = evq.pop_front();
      rx_data  = e.b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("we", mem_we, e.we);
      if (e.we) begin
        chk("addr", mem_addr, e.addr);
        chk("wdata", mem_wdata, e.data);
      end
      chk("done", done, e.dn);
      chk("error", error, e.er);
      chk("busy", busy, e.bs);
      chk("hold", cpu_hold, e.hd);
      g = $urandom_range(maxgap, 0);
      repeat (g) begin
        @(negedge clk);
        chk("gap_we", mem_we, 0);
        chk("gap_done", done, 0);
        chk("gap_error", error, 0);
        chk("gap_busy", busy, e.bs);
        chk("gap_hold", cpu_hold, e.hd);
      end
    end
    $display("xfer %s: %0d bytes, maxgap=%0d", label, nb, maxgap);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    hold_m   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    push_garbage(8'h00); push_garbage(8'hFF); push_garbage(8'h3C);
    run_queue("idle_garbage", 2);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_wdata, 0);

    wq.delete(); wq.push_back(32'h08000003); wq.push_back(32'h08000030);
    push_frame(2, 0);
    run_queue("plan_frame", 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    push_frame(2, 1);
    run_queue("bad_csum", 1);
    fill_words(3);
    push_frame(3, 0);
    run_queue("recover", 1);
`endif

    push_badlen(8'h41);
    run_queue("len65", 0);
    push_badlen(8'h00);
    run_queue("len0", 0);
    fill_words(64);
    push_frame(64, 0);
    run_queue("len64", 1);

    for (int it = 0; it < 25; it++) begin
      int sel;
      int n;
      bit corrupt;
      sel = $urandom_range(3, 0);
      corrupt = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(3, 0) == 0);
`endif
      if (sel <= 1) begin
        n = $urandom_range(8, 1);
        fill_words(n);
        push_frame(n, corrupt);
      end else if (sel == 2) begin
        push_badlen(($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 65)));
      end else begin
        for (int k = 0; k < $urandom_range(3, 1); k++) push_garbage(8'($urandom));
      end
      run_queue("rand", 3);
    end

    // Timeout: silence after A5 01 20 08
    push_ev(8'hA5, 0, 0, 0, 0, 0, 1, 1);
    push_ev(8'h01, 0, 0, 0, 0, 0, 1, 1);
    push_ev(8'h20, 0, 0, 0, 0, 0, 1, 1);
    push_ev(8'h08, 0, 0, 0, 0, 0, 1, 1);
    run_queue("timeout_pre", 0);
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      chk("to_error", error, k == 16);
      chk("to_busy", busy, k < 16);
      chk("to_we", mem_we, 0);
      chk("to_hold", cpu_hold, 1);
    end
    hold_m = 1'b1;
    fill_words(2);
    push_frame(2, 0);
    run_queue("after_timeout", 2);

    // Reset mid-frame
    fill_words(3);
    push_ev(8'hA5, 0, 0, 0, 0, 0, 1, 1);
    push_ev(8'h03, 0, 0, 0, 0, 0, 1, 1);
    for (int j = 0; j < 5; j++) begin
      push_ev(wq[j/4][31-8*(j%4) -: 8], j == 3, 0, wq[0], 0, 0, 1, 1);
    end
    run_queue("pre_reset", 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk_reset_vals("midrst2");
    reset  = 1'b1;
    hold_m = 1'b0;
    @(negedge clk);
    chk("postrst_error", error, 0);
    chk("postrst_hold", cpu_hold, 0);
    fill_words(4);
    push_frame(4, 0);
    run_queue("post_reset", 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
